// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        EXEC  = 2'd3
    } fetch_state_t;

    // Next-PC select driven by decode; anything other than PC_SEQ redirects.
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel: one valid/ready request, in-order responses.
interface pc_fetch_unit_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/Kogge_Stone.sv
// Parallel-prefix (Kogge-Stone) adder/subtractor; sub_en inverts b and injects a carry-in.
module Kogge_Stone #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_en,
    output logic [WIDTH-1:0] sum
);

    always_comb begin
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] p0;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g_nxt;
        logic [WIDTH-1:0] p_nxt;
        logic [WIDTH:0]   carry;

        bx = b ^ {WIDTH{sub_en}};
        g  = a & bx;
        p  = a ^ bx;
        p0 = p;
        // log2(WIDTH) prefix levels, span doubling each level
        for (int k = 0; (1 << k) < WIDTH; k++) begin
            g_nxt = g;
            p_nxt = p;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    g_nxt[i] = g[i] | (p[i] & g[i - (1 << k)]);
                    p_nxt[i] = p[i] & p[i - (1 << k)];
                end
            end
            g = g_nxt;
            p = p_nxt;
        end
        carry = {g | (p & {WIDTH{sub_en}}), sub_en};
        sum   = p0 ^ carry[WIDTH-1:0];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch: RESET -> REQ -> WAIT -> EXEC -> REQ.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              pc_control,
    input  logic [31:0]             branch_target,
    input  logic                    stall,
    pc_fetch_unit_if.master         imem,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             pc_out,
    output logic [31:0]             pc_incremented_four,
    output logic                    misaligned_fault
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         req_valid_q;
    logic [31:0]  next_pc;
    logic         advance;
    logic         redirect;

    Kogge_Stone #(
        .WIDTH (32)
    ) u_pc_adder (
        .a      (pc_q),
        .b      (PC_STEP),
        .sub_en (1'b0),
        .sum    (pc_incremented_four)
    );

    assign advance  = (state_q == EXEC) && !stall;
    assign redirect = (pc_control != PC_SEQ);

    always_comb begin
        next_pc = pc_incremented_four;
        if (redirect) begin
            next_pc = {branch_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        instr_q       <= imem.imem_rsp_data;
                        instr_valid_q <= 1'b1;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        pc_q          <= next_pc;
                        instr_valid_q <= 1'b0;
                        req_valid_q   <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                default: begin
                    state_q     <= RESET;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = pc_q;
    assign pc_out              = pc_q;
    assign instr               = instr_q;
    assign instr_valid         = instr_valid_q;
    // Reported in the redirect cycle itself so decode can trap the offending instruction.
    assign misaligned_fault    = advance && redirect && (branch_target[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table of fetch/execute steps plus reset/protocol corners.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_control;
    logic [31:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_incremented_four;
    logic        misaligned_fault;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch_unit_if imem ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_control          (pc_control),
        .branch_target       (branch_target),
        .stall               (stall),
        .imem                (imem),
        .instr_valid         (instr_valid),
        .instr               (instr),
        .pc_out              (pc_out),
        .pc_incremented_four (pc_incremented_four),
        .misaligned_fault    (misaligned_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  ctl;
        logic [31:0] target;
        logic        fault;
        int          ready_delay;
        int          stall_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for a request at addr, accepts it after ready_delay cycles, answers next cycle.
    task automatic fetch_instr(input logic [31:0] addr, input logic [31:0] data,
                               input int ready_delay);
        int waited = 0;
        while (imem.imem_req_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (imem.imem_req_valid !== 1'b1) begin
            check("req_valid timeout", {31'h0, imem.imem_req_valid}, 32'h1);
            return;
        end
        check("req_addr", imem.imem_req_addr, addr);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("req_valid held", {31'h0, imem.imem_req_valid}, 32'h1);
            check("req_addr held", imem.imem_req_addr, addr);
        end
        imem.imem_req_ready = 1'b1;
        @(negedge clk);
        imem.imem_req_ready = 1'b0;
        check("req_valid in wait", {31'h0, imem.imem_req_valid}, 32'h0);
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = data;
        @(negedge clk);
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'hDEAD_BEEF;
        check("instr_valid", {31'h0, instr_valid}, 32'h1);
        check("instr", instr, data);
        check("pc_out", pc_out, addr);
        check("pc_inc4", pc_incremented_four, addr + 32'd4);
    endtask

    task automatic exec_instr(input logic [1:0] ctl, input logic [31:0] target,
                              input logic fault);
        pc_control    = ctl;
        branch_target = target;
        #1;
        check("misaligned_fault", {31'h0, misaligned_fault}, {31'h0, fault});
        @(negedge clk);
        pc_control    = PC_SEQ;
        branch_target = 32'h0;
        #1;
        check("fault low after exec", {31'h0, misaligned_fault}, 32'h0);
        check("instr_valid drop", {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0013, PC_SEQ,  32'h0,         1'b0, 0, 0};
        vecs[1] = '{32'h0000_0104, 32'h0010_0093, PC_SEQ,  32'h0,         1'b0, 0, 0};
        vecs[2] = '{32'h0000_0108, 32'h0F80_006F, PC_JALR, 32'h0000_0200, 1'b0, 0, 0};
        vecs[3] = '{32'h0000_0200, 32'h1000_0063, PC_BRANCH, 32'h0000_0302, 1'b1, 0, 0};
        vecs[4] = '{32'h0000_0300, 32'h1000_006F, PC_JAL,  32'h0000_0400, 1'b0, 3, 2};
        vecs[5] = '{32'h0000_0400, 32'h0000_8067, PC_JALR, 32'hFFFF_FFFC, 1'b0, 0, 0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0020_0113, PC_SEQ,  32'h0,         1'b0, 0, 0};
        vecs[7] = '{32'h0000_0000, 32'h0030_0193, PC_SEQ,  32'h0,         1'b0, 0, 0};

        rst_n               = 1'b0;
        pc_control          = PC_SEQ;
        branch_target       = 32'h0;
        stall               = 1'b0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;

        repeat (2) @(negedge clk);
        check("reset pc_out", pc_out, 32'h0000_0100);
        check("reset req_valid", {31'h0, imem.imem_req_valid}, 32'h0);
        check("reset instr_valid", {31'h0, instr_valid}, 32'h0);
        check("reset instr", instr, 32'h0);
        check("reset fault", {31'h0, misaligned_fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_valid cycle 1", {31'h0, imem.imem_req_valid}, 32'h1);

        foreach (vecs[v]) begin
            fetch_instr(vecs[v].addr, vecs[v].data, vecs[v].ready_delay);
            for (int s = 0; s < vecs[v].stall_cycles; s++) begin
                stall         = 1'b1;
                pc_control    = PC_JALR;
                branch_target = 32'h0000_0999;
                #1;
                check("stall fault", {31'h0, misaligned_fault}, 32'h0);
                @(negedge clk);
                check("stall instr_valid", {31'h0, instr_valid}, 32'h1);
                check("stall instr", instr, vecs[v].data);
                check("stall pc_out", pc_out, vecs[v].addr);
            end
            stall = 1'b0;
            exec_instr(vecs[v].ctl, vecs[v].target, vecs[v].fault);
        end

        // Response while in REQ is a protocol error and must not touch instr.
        check("req after wrap", imem.imem_req_addr, 32'h0000_0004);
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem.imem_rsp_valid = 1'b0;
        check("stray rsp instr", instr, 32'h0030_0193);
        check("stray rsp instr_valid", {31'h0, instr_valid}, 32'h0);

        // Reset while waiting on a response.
        imem.imem_req_ready = 1'b1;
        @(negedge clk);
        imem.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid-wait rst pc_out", pc_out, 32'h0000_0100);
        check("mid-wait rst instr_valid", {31'h0, instr_valid}, 32'h0);
        check("mid-wait rst req_valid", {31'h0, imem.imem_req_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch_instr(32'h0000_0100, 32'h0040_0213, 0);
        exec_instr(PC_SEQ, 32'h0, 1'b0);
        check("post-reset next addr", imem.imem_req_addr, 32'h0000_0104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the RISC-V core. It holds the architectural PC, produces `pc_incremented_four` for the branch address calculator, and consumes the calculated branch target together with `pc_control` to pick the next PC. It runs a single-outstanding valid/ready request to instruction memory and presents one instruction at a time to decode, with stall and redirect-kill handling.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_control` input 2: next-PC select from decode of the current instruction; 2'b00 sequential, any other value redirects.
- `branch_target` input 32: target from the branch address calculator, valid while `instr_valid`.
- `stall` input 1: hazard hold; freezes the presented instruction and PC.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output 32: fetch address, always equal to `pc_out` when valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_rsp_valid` input 1: response data valid; one response per accepted request, in order.
- `imem_rsp_data` input 32: fetched instruction word.
- `instr_valid` output 1: `instr` and `pc_out` describe an executing instruction.
- `instr` output 32: registered instruction word.
- `pc_out` output 32: current PC.
- `pc_incremented_four` output 32: `pc_out` + 4, combinational, modulo 2^32.
- `misaligned_fault` output 1: one-cycle pulse when a redirect target has bits [1:0] != 0.

## Operation
- States: RESET, REQ, WAIT, EXEC.
- RESET: entered asynchronously while `rst_n`=0. Outputs: `pc_out`=`RESET_PC`, `imem_req_valid`=0, `instr_valid`=0, `instr`=0, `misaligned_fault`=0. On the first clock edge after release, go to REQ.
- REQ: `imem_req_valid`=1 with `imem_req_addr`=`pc_out`. On `imem_req_ready`=1, go to WAIT. Valid is not dropped and the address is not changed until accepted.
- WAIT: hold until `imem_rsp_valid`=1. Then capture `imem_rsp_data` into `instr` and go to EXEC.
- EXEC: `instr_valid`=1. While `stall`=1, hold `instr`, `pc_out` and state, and ignore `pc_control`.
- EXEC with `stall`=0, next PC:
  - `pc_control`=00: next PC = `pc_incremented_four`.
  - `pc_control`!=00: next PC = {`branch_target`[31:2], 2'b00}. If `branch_target`[1:0]!=0, `misaligned_fault` pulses in that same cycle (combinational on the EXEC cycle, registered low otherwise).
  - In both cases, `pc_out` updates and the unit goes to REQ.
- PC wrap: 32'hFFFF_FFFC + 4 gives 0, with no flag.
- Only one request may be outstanding. A response arriving in RESET, REQ or EXEC is a protocol error; it is ignored and `instr` is not modified.
- Reset asserted mid-WAIT: the outstanding response is lost. Memory is responsible for flushing on the same reset.

## Timing
- Minimum fetch-to-execute latency is 3 cycles per instruction: REQ (accepted at once), WAIT (response the next cycle), EXEC.
- Accept and response in the same cycle is not legal. A response is earliest one cycle after the accept.
- `instr_valid` rises on the edge after the response and falls on the edge after the EXEC cycle with `stall`=0.
- `pc_incremented_four` and `imem_req_addr` are combinational from the `pc_out` register. `instr`, `pc_out` and state are registered.
- `pc_control` and `branch_target` are sampled only on EXEC cycles with `stall`=0.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {RESET, REQ, WAIT, EXEC};
  - `pc_control` encoding localparams (`PC_SEQ`=2'b00);
  - `PC_STEP`=32'd4.
- The pc+4 adder is an instance of the existing `Kogge_Stone` adder with `sub_en`=0, so it matches the branch path. No other sub-modules.

## Test plan
- Reset release with `RESET_PC`=32'h100 and memory ready: `imem_req_addr`=0x100 on cycle 1; instruction at 0x100 valid on cycle 3; next request at 0x104.
- Sequential run over 4 instructions with zero-wait memory: `pc_out` steps 0x100→0x104→0x108→0x10C, and `pc_incremented_four` always equals `pc_out`+4.
- Redirect: in EXEC at 0x108, drive `pc_control`=2'b11 and `branch_target`=0x200. Next request address is 0x200 and `misaligned_fault` stays 0.
- Misaligned redirect: `pc_control`=2'b01 with `branch_target`=0x302. `misaligned_fault` pulses for 1 cycle and the next address is 0x300.
- Backpressure and stall: hold `imem_req_ready`=0 for 3 cycles (valid and address stable), then stall EXEC for 2 cycles. `instr` and `pc_out` stay unchanged and the redirect is taken only after stall drops.
- Wrap and reset: PC 0xFFFF_FFFC sequential gives 0x0000_0000. Asserting `rst_n`=0 in WAIT immediately forces `pc_out`=`RESET_PC` and `instr_valid`=0.
